// File: rtl/sc_mac_accumulate.sv
// Sequential MAC stage: one operand pair per cycle through the compressed SC
// multiplier into a saturating accumulator; result held until the consumer takes it.

// Behavioural stand-in for the compressed SC multiplier: exact unsigned 16x16 product.
module SC_Compress_dev_16_32 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [31:0] p_o
);
  assign p_o = {16'b0, a_i} * {16'b0, b_i};
endmodule

module sc_mac_accumulate #(
  parameter int DATA_WIDTH = 16,
  parameter int PROD_WIDTH = 32,
  parameter int ACC_WIDTH  = 40,
  parameter int CNT_WIDTH  = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_in_valid,
  output logic                  io_in_ready,
  input  logic [DATA_WIDTH-1:0] io_inputs_1,
  input  logic [DATA_WIDTH-1:0] io_inputs_0,
  input  logic                  io_in_last,
  output logic                  io_out_valid,
  input  logic                  io_out_ready,
  output logic [ACC_WIDTH-1:0]  io_out_data,
  output logic [CNT_WIDTH-1:0]  io_out_count,
  output logic                  io_out_sat
);
  typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] s1_a_q, s1_b_q;
  logic                  s1_v_q, s1_last_q;
  logic [PROD_WIDTH-1:0] p_q, mul_p;
  logic                  p_v_q, p_last_q;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  sat_q, sat_d;
  logic [ACC_WIDTH:0]    sum;
  logic                  in_hs, out_hs;

  SC_Compress_dev_16_32 u_mul (
    .a_i (s1_a_q),
    .b_i (s1_b_q),
    .p_o (mul_p)
  );

  assign io_in_ready  = (state_q == ACCUM);
  assign io_out_valid = (state_q == HOLD);
  assign io_out_data  = acc_q;
  assign io_out_count = count_q;
  assign io_out_sat   = sat_q;
  assign in_hs        = io_in_valid & io_in_ready;
  assign out_hs       = io_out_valid & io_out_ready;

  // One spare bit catches the overflow; the clip pins acc at all-ones.
  assign sum = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - PROD_WIDTH){1'b0}}, p_q};

  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    sat_d   = sat_q;
    if (out_hs) begin
      acc_d   = '0;
      count_d = '0;
      sat_d   = 1'b0;
    end else if (p_v_q) begin
      acc_d   = sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
      sat_d   = sat_q | sum[ACC_WIDTH];
      count_d = (&count_q) ? count_q : count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ACCUM;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_v_q    <= 1'b0;
      s1_last_q <= 1'b0;
      p_q       <= '0;
      p_v_q     <= 1'b0;
      p_last_q  <= 1'b0;
      acc_q     <= '0;
      count_q   <= '0;
      sat_q     <= 1'b0;
    end else begin
      s1_v_q    <= in_hs;
      s1_last_q <= in_hs & io_in_last;
      if (in_hs) begin
        s1_a_q <= io_inputs_1;
        s1_b_q <= io_inputs_0;
      end
      p_q      <= (s1_a_q == '0 || s1_b_q == '0) ? '0 : mul_p;
      p_v_q    <= s1_v_q;
      p_last_q <= s1_last_q;
      acc_q    <= acc_d;
      count_q  <= count_d;
      sat_q    <= sat_d;
      case (state_q)
        ACCUM:   if (in_hs && io_in_last) state_q <= DRAIN;
        DRAIN:   if (p_v_q && p_last_q)   state_q <= HOLD;
        HOLD:    if (io_out_ready)        state_q <= ACCUM;
        default: state_q <= ACCUM;
      endcase
    end
  end
endmodule

// File: doc/sc_mac_accumulate.md
# sc_mac_accumulate

Sequential multiply-accumulate stage for SC dot products. Accepts one operand pair per cycle over a valid/ready handshake and feeds it through an internal instance of SC_Compress_dev_16_32. Sums the 32-bit products into a saturating accumulator. Emits the total on a valid/ready output once the pair flagged `last` has fully drained. Sits directly downstream of the compressed SC multiplier and turns per-pair products into vector results for the PE datapath.

## Interface
- DATA_WIDTH, 16, operand width; fixed by the multiplier instance
- PROD_WIDTH, 32, product width from the multiplier
- ACC_WIDTH, 40, accumulator / result width; legal range 33..48
- CNT_WIDTH, 10, width of the accumulated-pair counter

- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- io_in_valid  input  1  operand pair valid
- io_in_ready  output  1  block can accept a pair this cycle
- io_inputs_1  input  DATA_WIDTH  operand A (unsigned)
- io_inputs_0  input  DATA_WIDTH  operand B (unsigned)
- io_in_last  input  1  marks the final pair of the current vector
- io_out_valid  output  1  result valid
- io_out_ready  input  1  consumer accepts result
- io_out_data  output  ACC_WIDTH  accumulated sum
- io_out_count  output  CNT_WIDTH  pairs in this sum; saturates at all-ones
- io_out_sat  output  1  sticky flag: accumulator clipped during this vector

## Operation
- FSM states: ACCUM, DRAIN, HOLD. Reset state is ACCUM.
- **ACCUM**
  - io_in_ready=1.
  - Input handshake (valid&ready) captures the operands and last into stage-1 registers (s1_a, s1_b, s1_v, s1_last).
  - A handshake with io_in_last=1 moves the FSM to DRAIN.
- **DRAIN**
  - io_in_ready=0.
  - Waits for the last pair to reach the accumulator.
  - Moves to HOLD on the same edge the final product is summed.
- **HOLD**
  - io_in_ready=0 and io_out_valid=1.
  - io_out_data, io_out_count and io_out_sat are stable until the output handshake.
  - On the handshake: acc, count and sat clear to 0, and the FSM returns to ACCUM.
- **Stage 1 to stage 2**
  - The SC_Compress_dev_16_32 instance is combinational on s1_a/s1_b.
  - Its output is registered into p_reg with p_v=s1_v and p_last=s1_last.
  - If s1_a==0 or s1_b==0, p_reg is forced to 0, bypassing the multiplier result.
- **Accumulate**, when p_v=1:
  - acc <= min(acc + zero-extended p_reg, 2^ACC_WIDTH-1).
  - sat <= sat | clipped.
  - count <= count+1, saturating at all-ones.
- io_out_data, io_out_count and io_out_sat are direct register outputs of acc, count and sat.
- Arithmetic is unsigned. The sum is computed at ACC_WIDTH+1 bits, then clipped.
- A vector is any run of ≥1 pairs ending in last. No zero-length vectors exist.

## Timing
- Reset values: io_in_ready=1 (combinational from state=ACCUM); io_out_valid=0; io_out_data=0; io_out_count=0; io_out_sat=0; all pipeline valids 0; FSM=ACCUM.
- Throughput: one pair per cycle in ACCUM with no bubbles required.
- Pipeline: pair accepted at edge E → product in p_reg after E+1 → summed into acc at E+2.
- Latency: a last pair accepted at edge E gives io_out_valid=1 after edge E+2.
- Result: io_out_data equals the sum of all pairs of the vector.
- Backpressure: the block holds HOLD indefinitely while io_out_ready=0, with outputs unchanged.
- Earliest next vector: the first pair of the next vector can be accepted the cycle after the output handshake. Minimum vector period is N+3 cycles for N pairs.
- io_in_valid=0 in ACCUM: nothing is captured and the bubble propagates with valid=0.
- io_in_valid in DRAIN/HOLD is ignored; the upstream stage must hold its pair.
- Reset asserted mid-vector or in HOLD: all state clears immediately (asynchronous) and the partial sum is discarded.
- Saturation: once acc reaches 2^ACC_WIDTH-1 it stays there for the rest of the vector. Count still increments.

## Test plan
- **Zero vector:** 4 pairs with operand A=0x0000 (any B), last on the 4th → out_valid 2 cycles after the 4th accept; data=0, count=4, sat=0.
- **Single pair:** A=0xFFFF, B=0xFFFF with last → out_valid 2 cycles later; data equals the SC_Compress_dev_16_32 model product for that pair, zero-extended; count=1.
- **Back-to-back stream:** 8 random nonzero pairs with valid held high → in_ready=1 for all 8 cycles; data=Σ model products; count=8.
- **Output backpressure:** hold out_ready=0 for 10 cycles in HOLD → in_ready=0 and data/count stable throughout. Raise out_ready: handshake, then in_ready=1 next cycle, and the next vector's sum starts from 0.
- **Saturation:** ACC_WIDTH=33, repeated 0xFFFF/0xFFFF pairs, 6 per vector → data=2^33-1 and sat=1 (rising no later than the 4th product); count=6. The next vector has sat=0.
- **Reset mid-vector:** assert reset after 3 of 5 pairs → out_valid=0, in_ready=1, count=0 while reset is held. A fresh 2-pair vector then gives count=2 and only its own sum.
